// File: rtl/fft_sdf_stage_ctrl_if.sv
// Handshake and control bundle between an SDF stage controller and its stage datapath.
// The master drives samples in; the slave (the controller) returns sequencing outputs.
interface fft_sdf_stage_ctrl_if #(
  parameter int unsigned TW_AW = 8
);
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [1:0]       state;
  logic [TW_AW-1:0] tw_addr;
  logic             tw_en;
  logic             out_valid;
  logic             done;
  logic             err;

  modport master (
    output in_valid, in_last,
    input  in_ready, state, tw_addr, tw_en, out_valid, done, err
  );

  modport slave (
    input  in_valid, in_last,
    output in_ready, state, tw_addr, tw_en, out_valid, done, err
  );
endinterface

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: phase counter, FILL/BFLY/TWID FSM,
// twiddle ROM addressing and post-stream drain of the delay line.
module fft_sdf_stage_ctrl #(
  parameter int unsigned HALF     = 16,
  parameter int unsigned LOG_HALF = 4,
  parameter int unsigned TW_STEP  = 1,
  parameter int unsigned TW_AW    = 8
) (
  input logic                clk,
  input logic                rst,
  fft_sdf_stage_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StBfly = 2'd1,
    StTwid = 2'd2
  } state_e;

  localparam logic [LOG_HALF-1:0] PLast = LOG_HALF'(HALF - 1);

  state_e              state_q, state_d;
  logic [LOG_HALF-1:0] p_q, p_d;
  logic                drain_q, drain_d;
  logic [TW_AW-1:0]    tw_addr_q, tw_addr_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic acc, adv, last_pos;

  assign acc      = bus.in_valid & ~drain_q;
  assign adv      = acc | drain_q;
  assign last_pos = (p_q == PLast);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    err_d   = err_q;

    if (adv) begin
      p_d = p_q + LOG_HALF'(1);
      if (last_pos) begin
        case (state_q)
          StFill: state_d = StBfly;
          StBfly: state_d = StTwid;
          StTwid: begin
            if (drain_q) begin
              state_d = StFill;
              drain_d = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = StBfly;
            end
          end
          default: state_d = StFill;
        endcase
      end
    end

    // Only a last sample closing a BFLY block leaves a half in the delay line to drain.
    if (acc && bus.in_last) begin
      if (state_q == StBfly && last_pos) begin
        drain_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    // Address is precomputed from next-state so it lines up with the sample seen next cycle.
    tw_addr_d = (state_d == StTwid) ? TW_AW'(32'(p_d) * TW_STEP) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFill;
      p_q       <= '0;
      drain_q   <= 1'b0;
      tw_addr_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      drain_q   <= drain_d;
      tw_addr_q <= tw_addr_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready  = ~drain_q;
  assign bus.state     = state_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.tw_en     = adv & (state_q == StTwid);
  assign bus.out_valid = adv & (state_q != StFill);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Randomized and directed bench for fft_sdf_stage_ctrl, checked against a
// sample-position reference model; two instances cover TW_STEP=1 and TW_STEP=2.
module tb_fft_sdf_stage_ctrl;
  localparam int unsigned HALF     = 16;
  localparam int unsigned LOG_HALF = 4;
  localparam int unsigned TW_AW    = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_sdf_stage_ctrl_if #(.TW_AW(TW_AW)) bus1 ();
  fft_sdf_stage_ctrl_if #(.TW_AW(TW_AW)) bus2 ();

  fft_sdf_stage_ctrl #(
    .HALF(HALF), .LOG_HALF(LOG_HALF), .TW_STEP(1), .TW_AW(TW_AW)
  ) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  fft_sdf_stage_ctrl #(
    .HALF(HALF), .LOG_HALF(LOG_HALF), .TW_STEP(2), .TW_AW(TW_AW)
  ) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  // Model: pos counts advances since stream start; drain_left counts remaining drain cycles.
  int unsigned pos;
  int unsigned drain_left;
  bit          err_m;
  bit          done_m;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int unsigned model_state();
    if (pos < HALF) return 0;
    return ((pos / HALF) % 2 == 1) ? 1 : 2;
  endfunction

  task automatic drive(input bit v, input bit l);
    bus1.in_valid = v;
    bus1.in_last  = l;
    bus2.in_valid = v;
    bus2.in_last  = l;
  endtask

  task automatic check_reset_values();
    check("rst_state",     bus1.state,     0);
    check("rst_tw_addr",   bus1.tw_addr,   0);
    check("rst_tw_en",     bus1.tw_en,     0);
    check("rst_out_valid", bus1.out_valid, 0);
    check("rst_in_ready",  bus1.in_ready,  1);
    check("rst_done",      bus1.done,      0);
    check("rst_err",       bus1.err,       0);
    check("rst_state2",    bus2.state,     0);
    check("rst_tw_addr2",  bus2.tw_addr,   0);
    check("rst_in_ready2", bus2.in_ready,  1);
  endtask

  // Asserts reset mid-cycle, checks outputs before any clock edge, then releases.
  task automatic do_reset();
    drive(1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_values();
    pos        = 0;
    drain_left = 0;
    err_m      = 0;
    done_m     = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // One clock cycle: apply inputs, compare against model, then advance the model.
  task automatic step(input bit v, input bit l);
    int unsigned st, ph, exp_addr1, exp_addr2;
    bit rdy, acc, adv;
    drive(v, l);
    #1;
    rdy = (drain_left == 0);
    acc = v && rdy;
    adv = acc || (drain_left > 0);
    st  = model_state();
    ph  = pos % HALF;
    exp_addr1 = (st == 2) ? (ph * 1) % (1 << TW_AW) : 0;
    exp_addr2 = (st == 2) ? (ph * 2) % (1 << TW_AW) : 0;

    check("state",     bus1.state,     st);
    check("tw_addr",   bus1.tw_addr,   exp_addr1);
    check("tw_en",     bus1.tw_en,     (adv && st == 2) ? 1 : 0);
    check("out_valid", bus1.out_valid, (adv && st != 0) ? 1 : 0);
    check("in_ready",  bus1.in_ready,  rdy ? 1 : 0);
    check("done",      bus1.done,      done_m ? 1 : 0);
    check("err",       bus1.err,       err_m ? 1 : 0);
    check("state_s2",  bus2.state,     st);
    check("tw_addr_s2", bus2.tw_addr,  exp_addr2);
    check("tw_en_s2",  bus2.tw_en,     (adv && st == 2) ? 1 : 0);

    @(posedge clk);
    #1;
    done_m = 0;
    if (drain_left > 0) begin
      drain_left--;
      pos++;
      if (drain_left == 0) begin
        pos    = 0;
        done_m = 1;
      end
    end else if (acc) begin
      if (l) begin
        if (st == 1 && ph == HALF - 1) drain_left = HALF;
        else err_m = 1;
      end
      pos++;
    end
  endtask

  function automatic bit at_legal_last();
    return (drain_left == 0) && (model_state() == 1) && (pos % HALF == HALF - 1);
  endfunction

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Fill and steady state: 80 continuous samples.
    repeat (80) step(1'b1, 1'b0);

    // Gap in TWID at p=5.
    do_reset();
    repeat (37) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b0);

    // Drain after a legal last on sample 32, with in_valid held high throughout.
    do_reset();
    repeat (31) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (16) step(1'b1, 1'b0);
    repeat (20) step(1'b1, 1'b0);

    // Illegal last on sample 20, then a legal drain interrupted by reset at drain cycle 7.
    do_reset();
    repeat (19) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (30) step(1'b1, 1'b0);
    for (int i = 0; i < 64 && !at_legal_last(); i++) step(1'b1, 1'b0);
    check("reached_legal_last", at_legal_last() ? 1 : 0, 1);
    step(1'b1, 1'b1);
    repeat (6) step(1'b1, 1'b0);
    check("mid_drain_in_ready", bus1.in_ready, 0);
    do_reset();

    // Randomized traffic with gaps, legal and illegal lasts, and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bit v, l;
      v = ($urandom_range(0, 3) != 0);
      if (at_legal_last()) l = $urandom_range(0, 1) == 1;
      else                 l = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 599) == 0) do_reset();
      else step(v, l);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end
endmodule
